// File: rtl/master_package.sv
`default_nettype none
// ============================================================================
//  master_package
//  Shared AHB-Lite types and constants used by the register-file memory
//  controller: transfer size/type encodings, response codes and the
//  controller state encoding.
//  Revision: 1.0
// ============================================================================
package master_package;

    // HSIZE encodings accepted by the register file; all other codes are illegal
    typedef enum logic [2:0] {
        BYTE      = 3'b000,
        HALF_WORD = 3'b001,
        WORD      = 3'b010
    } HSIZE_E;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_E;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RD     = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } ctrl_state_e;

    // Number of bytes touched by a transfer; 0 flags an unsupported size code
    function automatic logic [3:0] size_bytes(input HSIZE_E size);
        case (size)
            BYTE:      return 4'd1;
            HALF_WORD: return 4'd2;
            WORD:      return 4'd4;
            default:   return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mem_wait_cnt.sv
`default_nettype none
// ============================================================================
//  ahb_mem_wait_cnt
//  Loadable down-counter that times the WAIT state. done is high while the
//  count is zero, i.e. in the last wait cycle.
//  Revision: 1.0
// ============================================================================
module ahb_mem_wait_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and saturate at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/ahb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  ahb_mem_ctrl
//  AHB-Lite slave controller for a 256-byte register-file memory. Accepts
//  address phases, checks legality, inserts WAIT_STATES wait cycles, issues
//  one-cycle read/write strobes and returns OKAY or a two-cycle ERROR.
//  Optional feature macro: AHB_MEM_CTRL_ALIGN_CHECK_EN (misalignment -> ERROR).
//  Revision: 1.0
// ============================================================================
module ahb_mem_ctrl
    import master_package::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  HSIZE_E      HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_addr,
    output HSIZE_E      mem_size,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    ctrl_state_e state, state_next;
    logic [7:0]  addr_q;
    logic        write_q;
    HSIZE_E      size_q;

    logic        ready_phase;
    logic        accept;
    logic [3:0]  nbytes;
    logic        size_ok, range_ok, align_ok, legal;
    logic        cnt_load;
    logic [3:0]  cnt_val;
    logic        cnt_done;

    // A new address phase can only be taken while this slave is not stalling
    assign ready_phase = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
    assign accept      = ready_phase && HSEL && HREADY &&
                         ((HTRANS == NONSEQ) || (HTRANS == SEQ));

    // Legality of the transfer being captured this cycle (these are exactly the
    // values loaded into the capture registers, so the first data-phase state
    // can be chosen without an extra decode cycle)
    always_comb begin
        nbytes   = size_bytes(HSIZE);
        size_ok  = (HSIZE == BYTE) || (HSIZE == HALF_WORD) || (HSIZE == WORD);
        range_ok = ({1'b0, HADDR} + {5'd0, nbytes}) <= 9'd256;
        align_ok = 1'b1;
`ifdef AHB_MEM_CTRL_ALIGN_CHECK_EN
        align_ok = !(((HSIZE == HALF_WORD) && HADDR[0]) ||
                     ((HSIZE == WORD) && (HADDR[1:0] != 2'b00)));
`endif
        legal    = size_ok && range_ok && align_ok;
    end

    // Capture address-phase control on acceptance
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= 8'd0;
            write_q <= 1'b0;
            size_q  <= BYTE;
        end else if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
        end
    end

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter load and bus/memory outputs
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = 4'd0;
        case (state)
            ST_IDLE, ST_ACCESS, ST_ERR2: begin
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (HWRITE) begin
                        if (WS != 4'd0) begin
                            state_next = ST_WAIT;
                            cnt_load   = 1'b1;
                            cnt_val    = WS - 4'd1;
                        end else begin
                            state_next = ST_ACCESS;
                        end
                    end else begin
                        state_next = ST_RD;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            // The RD cycle already counts as one wait cycle of a read
            ST_RD: begin
                if (WS > 4'd1) begin
                    state_next = ST_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = WS - 4'd2;
                end else begin
                    state_next = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase

        HREADYOUT = !((state == ST_WAIT) || (state == ST_RD) || (state == ST_ERR1));
        HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        mem_we    = (state == ST_ACCESS) && write_q;
        mem_re    = (state == ST_RD);
        HRDATA    = ((state == ST_ACCESS) && !write_q) ? mem_rdata : 32'd0;
        mem_wdata = mem_we ? HWDATA : 32'd0;
    end

    assign mem_addr = addr_q;
    assign mem_size = size_q;

    ahb_mem_wait_cnt #(
        .WIDTH (4)
    ) u_wait_cnt (
        .clk      (HCLK),
        .rst      (HRESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state == ST_WAIT),
        .done     (cnt_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_ahb_mem_ctrl
//  Two controller instances (WAIT_STATES 0 and 3) share one AHB master; only
//  one is selected at a time. Expected events are queued when a transfer is
//  issued and a monitor pops them as the selected slave produces strobes and
//  completions. A small byte-array memory sits behind each instance.
//  Revision: 1.0
// ============================================================================
module tb_ahb_mem_ctrl;
    import master_package::*;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    localparam logic [2:0] EV_WR    = 3'd1;
    localparam logic [2:0] EV_RE    = 3'd2;
    localparam logic [2:0] EV_RDONE = 3'd3;
    localparam logic [2:0] EV_ERR   = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [4:0]  waits;   // HREADYOUT-low cycles before completion
        logic [4:0]  rlow;    // of those, cycles with HRESP high
        logic        resp;    // HRESP in the completing cycle
    } ev_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic        seq;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset;
    logic        hsel;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize_raw;
    logic [31:0] hwdata;
    logic        cur;
    logic        init_req;

    logic        sel    [2];
    logic        ro     [2];
    logic        resp   [2];
    logic        we     [2];
    logic        re     [2];
    logic [31:0] hrdata [2];
    logic [31:0] wdo    [2];
    logic [31:0] rdin   [2];
    logic [7:0]  maddr  [2];
    HSIZE_E      msize  [2];
    logic        hready_bus;

    assign sel[0]     = hsel && !cur;
    assign sel[1]     = hsel && cur;
    assign hready_bus = cur ? ro[1] : ro[0];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_mem_ctrl #(
            .WAIT_STATES ((g == 0) ? WS0 : WS1)
        ) u_dut (
            .HCLK      (clk),
            .HRESET    (hreset),
            .HSEL      (sel[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (HSIZE_E'(hsize_raw)),
            .HWDATA    (hwdata),
            .HREADY    (hready_bus),
            .HREADYOUT (ro[g]),
            .HRESP     (resp[g]),
            .HRDATA    (hrdata[g]),
            .mem_we    (we[g]),
            .mem_re    (re[g]),
            .mem_addr  (maddr[g]),
            .mem_size  (msize[g]),
            .mem_wdata (wdo[g]),
            .mem_rdata (rdin[g])
        );
    end

    function automatic logic [7:0] init_byte(input int k, input int a);
        return 8'(a * 29 + k * 101 + 7);
    endfunction

    function automatic int nb_of(input logic [2:0] s);
        return (s <= 3'd2) ? (1 << s) : 1;
    endfunction

    // Byte-addressed memory behind each controller; read data zero-extended
    logic [7:0] env_mem [2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_req) begin
                for (int a = 0; a < 256; a++) env_mem[k][a] <= init_byte(k, a);
            end else begin
                if (we[k])
                    for (int i = 0; i < nb_of(msize[k]); i++)
                        env_mem[k][8'(maddr[k] + 8'(i))] <= wdo[k][8*i +: 8];
                if (re[k]) begin
                    logic [31:0] tmp;
                    tmp = 32'd0;
                    for (int i = 0; i < nb_of(msize[k]); i++)
                        tmp[8*i +: 8] = env_mem[k][8'(maddr[k] + 8'(i))];
                    rdin[k] <= tmp;
                end
            end
        end
    end

    int    checks = 0;
    int    errors = 0;
    ev_t   exp_q[$];
    logic [7:0] ref_mem [2][256];
    xfer_t bq[$];

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input int k, input string name);
        chk(name, 96'({ro[k], resp[k], hrdata[k], we[k], re[k], maddr[k], 3'(msize[k]), wdo[k]}),
            96'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 3'(BYTE), 32'd0}));
    endtask

    task automatic cmp_ev(input int k, input ev_t obs);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ev_unexpected inst%0d got kind=%0d addr=%h data=%h waits=%0d", k, obs.kind, obs.addr, obs.data, obs.waits);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL ev inst%0d got kind=%0d addr=%h size=%0d data=%h waits=%0d rlow=%0d resp=%0d exp kind=%0d addr=%h size=%0d data=%h waits=%0d rlow=%0d resp=%0d",
                         k, obs.kind, obs.addr, obs.size, obs.data, obs.waits, obs.rlow, obs.resp,
                         e.kind, e.addr, e.size, e.data, e.waits, e.rlow, e.resp);
            end
        end
    endtask

    // Watches both slaves mid-cycle and turns their activity into events
    task automatic monitor_loop();
        int low [2];
        int rlo [2];
        bit pend[2];
        ev_t obs;
        for (int k = 0; k < 2; k++) begin low[k] = 0; rlo[k] = 0; pend[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (hreset) begin
                    low[k] = 0; rlo[k] = 0; pend[k] = 0;
                end else begin
                    if (!we[k]) chk("wdata_idle_zero", 96'(wdo[k]), 96'd0);
                    if (!ro[k]) begin
                        low[k]++;
                        if (resp[k]) rlo[k]++;
                        if (!pend[k]) chk("hrdata_zero", 96'(hrdata[k]), 96'd0);
                    end else begin
                        if (we[k]) begin
                            obs = '{EV_WR, maddr[k], 3'(msize[k]), wdo[k], 5'(low[k]), 5'(rlo[k]), resp[k]};
                            cmp_ev(k, obs);
                        end else if (resp[k]) begin
                            obs = '{EV_ERR, 8'd0, 3'd0, 32'd0, 5'(low[k]), 5'(rlo[k]), 1'b1};
                            cmp_ev(k, obs);
                        end else if (pend[k]) begin
                            obs = '{EV_RDONE, 8'd0, 3'd0, hrdata[k], 5'(low[k]), 5'(rlo[k]), resp[k]};
                            cmp_ev(k, obs);
                            pend[k] = 0;
                        end
                        if (!pend[k] || we[k] || resp[k])
                            if (!(pend[k] && !we[k] && !resp[k]))
                                chk("hrdata_zero", 96'(we[k] || resp[k] || !pend[k] ? (obs.kind == EV_RDONE && !we[k] && !resp[k] ? 32'd0 : hrdata[k]) : 32'd0), 96'd0);
                        low[k] = 0; rlo[k] = 0;
                    end
                    if (re[k]) begin
                        obs = '{EV_RE, maddr[k], 3'(msize[k]), 32'd0, 5'd0, 5'd0, resp[k]};
                        cmp_ev(k, obs);
                        pend[k] = 1;
                    end
                end
            end
        end
    endtask

    // Reference model: decides the outcome of a transfer from the rules alone
    task automatic predict(input xfer_t x);
        int  w  = cur ? WS1 : WS0;
        int  nb = 1 << x.size;
        bit  legal;
        logic [31:0] d;
        legal = (x.size <= 3'd2) && (int'(x.addr) + nb <= 256);
`ifdef AHB_MEM_CTRL_ALIGN_CHECK_EN
        if ((x.size <= 3'd2) && ((int'(x.addr) % nb) != 0)) legal = 0;
`endif
        if (!legal) begin
            exp_q.push_back('{EV_ERR, 8'd0, 3'd0, 32'd0, 5'd1, 5'd1, 1'b1});
        end else if (x.write) begin
            exp_q.push_back('{EV_WR, x.addr, x.size, x.wdata, 5'(w), 5'd0, 1'b0});
            for (int i = 0; i < nb; i++) ref_mem[cur][int'(x.addr) + i] = x.wdata[8*i +: 8];
        end else begin
            d = 32'd0;
            for (int i = 0; i < nb; i++) d[8*i +: 8] = ref_mem[cur][int'(x.addr) + i];
            exp_q.push_back('{EV_RE, x.addr, x.size, 32'd0, 5'd0, 5'd0, 1'b0});
            exp_q.push_back('{EV_RDONE, 8'd0, 3'd0, d, 5'((w > 1) ? w : 1), 5'd0, 1'b0});
        end
    endtask

    task automatic drive_addr(input xfer_t x);
        hsel      = 1'b1;
        haddr     = x.addr;
        htrans    = x.seq ? 2'b11 : 2'b10;
        hwrite    = x.write;
        hsize_raw = x.size;
        predict(x);
    endtask

    // Advance clock edges until one closes a cycle with the bus ready
    task automatic step_until_ready();
        bit ok = 0;
        int n  = 0;
        while (!ok) begin
            ok = hready_bus;
            @(posedge clk); #1;
            n++;
            if (!ok && n > 40) begin
                checks++; errors++;
                $display("FAIL ready_timeout inst%0d waited=%0d", cur, n);
                ok = 1;
            end
        end
    endtask

    task automatic run_burst(input logic inst, input logic end_sel);
        cur = inst;
        drive_addr(bq[0]);
        step_until_ready();
        for (int i = 0; i < bq.size(); i++) begin
            hwdata = bq[i].wdata;
            if (i + 1 < bq.size()) begin
                drive_addr(bq[i + 1]);
            end else begin
                hsel = end_sel; htrans = 2'b00; haddr = 8'd0; hwrite = 1'b0;
            end
            step_until_ready();
        end
        hwdata = 32'd0;
    endtask

    function automatic xfer_t mk(input logic [7:0] a, input logic [2:0] s, input logic w, input logic [31:0] d);
        return '{a, s, w, d, 1'b0};
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
        if (($urandom_range(0, 1) == 1) && (x.size <= 3'd2)) x.addr = x.addr & ~8'((1 << x.size) - 1);
        x.write = 1'($urandom);
        x.wdata = $urandom;
        x.seq   = 1'($urandom);
        return x;
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        hreset = 1'b1; init_req = 1'b1; cur = 1'b0;
        hsel = 1'b0; haddr = 8'd0; htrans = 2'b00; hwrite = 1'b0; hsize_raw = 3'd0; hwdata = 32'd0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_byte(k, a);
        fork
            monitor_loop();
        join_none
        @(posedge clk); #1; init_req = 1'b0;
        @(negedge clk);
        chk_reset_vals(0, "reset_inst0");
        chk_reset_vals(1, "reset_inst1");
        @(posedge clk); #1; hreset = 1'b0;
        @(posedge clk); #1;

        // Zero-wait slave: word write/read, half-word at odd address, range error
        bq = '{mk(8'h10, 3'(WORD), 1'b1, 32'hDEADBEEF)};           run_burst(1'b0, 1'b0);
        bq = '{mk(8'h10, 3'(WORD), 1'b0, 32'd0)};                  run_burst(1'b0, 1'b0);
        bq = '{mk(8'h01, 3'(HALF_WORD), 1'b1, 32'h0000C3D2)};      run_burst(1'b0, 1'b0);
        bq = '{mk(8'hFE, 3'(WORD), 1'b0, 32'd0)};                  run_burst(1'b0, 1'b0);
        bq = '{mk(8'h00, 3'(WORD), 1'b1, 32'h11223344), mk(8'h04, 3'(WORD), 1'b1, 32'h55667788)};
        run_burst(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("sel_idle_okay", 96'({hready_bus, resp[0]}), 96'({1'b1, 1'b0}));
            @(posedge clk); #1;
        end
        hsel = 1'b0;

        // Three-wait slave: byte write, then reset during a read's wait state
        bq = '{mk(8'h03, 3'(BYTE), 1'b1, 32'h000000A5)};           run_burst(1'b1, 1'b0);
        cur = 1'b1; hsel = 1'b1; haddr = 8'h20; htrans = 2'b10; hwrite = 1'b0; hsize_raw = 3'(WORD);
        exp_q.push_back('{EV_RE, 8'h20, 3'(WORD), 32'd0, 5'd0, 5'd0, 1'b0});
        @(posedge clk); #1; hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
        chk("pre_reset_stall", 96'(ro[1]), 96'd0);
        hreset = 1'b1; #1;
        chk_reset_vals(1, "reset_mid_read");
        @(posedge clk); #1; hreset = 1'b0;
        @(posedge clk); #1;
        bq = '{mk(8'h20, 3'(WORD), 1'b1, 32'h12345678), mk(8'h20, 3'(WORD), 1'b0, 32'd0)};
        run_burst(1'b1, 1'b0);

        // Randomized bursts on either slave with idle/busy gaps
        for (int it = 0; it < 60; it++) begin
            int n;
            n = $urandom_range(1, 4);
            bq.delete();
            for (int j = 0; j < n; j++) bq.push_back(rand_xfer());
            run_burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                hsel = 1'b1; htrans = 2'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("idle_busy_okay", 96'({hready_bus, cur ? resp[1] : resp[0]}), 96'({1'b1, 1'b0}));
            end
            hsel = 1'b0; htrans = 2'b00;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 96'(exp_q.size()), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_mem_ctrl.md
# ahb_mem_ctrl

AHB-Lite slave-side controller that sequences the 256-byte register-file memory behind the slave port. It captures valid address phases and checks each transfer for legality. It inserts a configurable number of wait states, drives the single-cycle write/read strobes to the memory, and returns OKAY or the two-cycle ERROR response. It sits between the slave decoder/mux and the byte-addressed register file.

## Interface
- WAIT_STATES, 0, extra HREADYOUT-low cycles per legal write data phase (0–15).
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  8  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  HSIZE_E  BYTE / HALF_WORD / WORD.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready (HREADYIN).
- HREADYOUT  out  1  slave ready; reset 1.
- HRESP  out  1  0 = OKAY, 1 = ERROR; reset 0.
- HRDATA  out  32  read data, valid only in the final read data-phase cycle, else 0; reset 0.
- mem_we  out  1  one-cycle write strobe; reset 0.
- mem_re  out  1  one-cycle read strobe; reset 0.
- mem_addr  out  8  captured address; reset 0.
- mem_size  out  HSIZE_E  captured size; reset BYTE.
- mem_wdata  out  32  HWDATA passthrough while mem_we is high, else 0.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re (zero-extended by memory).

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. HADDR, HWRITE and HSIZE are registered and the FSM moves to the data phase.
- HSEL with IDLE/BUSY, or HSEL low: zero-wait OKAY, no memory strobe.
- Legality checks are made on the captured values:
  - HSIZE not BYTE/HALF_WORD/WORD → error.
  - addr + bytes − 1 > 255 → error; no wrap-around access is allowed.
  - Misalignment → error (see Configuration).
- FSM states: IDLE, WAIT, RD, ACCESS, ERR1, ERR2.
- Transitions:
  - IDLE → ERR1 for an illegal transfer.
  - IDLE → WAIT for a legal write with WAIT_STATES > 0, otherwise IDLE → ACCESS.
  - IDLE → RD for a legal read.
  - RD → WAIT if WAIT_STATES > 1, else RD → ACCESS.
  - WAIT → ACCESS when the counter expires.
  - ACCESS or ERR2 → IDLE, or straight into the next data phase if a new address phase is accepted in that cycle (back-to-back).
  - ERR1 → ERR2.
- Writes: mem_we = 1 in the ACCESS cycle with mem_wdata = HWDATA.
- Reads: mem_re = 1 in the RD cycle, which is the first data-phase cycle. HRDATA = mem_rdata in the ACCESS cycle.
- Error response: no memory strobe.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.

## Timing
- Write data phase = WAIT_STATES + 1 cycles.
- Read data phase = max(WAIT_STATES, 1) + 1 cycles.
- HREADYOUT is low in every data-phase cycle except ACCESS and ERR2.
- Address phases presented while HREADYOUT = 0 are ignored; the master holds them per protocol.
- SEQ is treated identically to NONSEQ. Burst address increment is the master's responsibility.
- Back-to-back transfers: the address phase accepted in ACCESS/ERR2 starts its data phase on the next cycle, with no idle gap.
- Reset asserted mid-transfer immediately forces IDLE and the reset output values. A strobe cut short by reset is not replayed.
- The WAIT counter reloads on each new data phase.

## Configuration
- AHB_MEM_CTRL_ALIGN_CHECK_EN
  - Defined: HALF_WORD with addr[0] ≠ 0, or WORD with addr[1:0] ≠ 0, gets the two-cycle ERROR response and no strobe.
  - Undefined: misaligned transfers proceed as legal accesses at the unaligned byte address.
  - The range and HSIZE checks apply in both builds.

## Structure
- HSIZE_E (BYTE/HALF_WORD/WORD) stays in master_package.
- Add to master_package:
  - HTRANS_E (IDLE/BUSY/NONSEQ/SEQ);
  - HRESP_OKAY/HRESP_ERROR constants;
  - the controller state enum.
- One sub-module, ahb_mem_wait_cnt: loadable down-counter with a done flag, reset 0, used for the WAIT state.

## Test plan
- WAIT_STATES=0, WORD write 0xDEADBEEF @0x10, then read @0x10:
  - write: HREADYOUT never low, mem_we one cycle;
  - read: one wait cycle, HRDATA = 0xDEADBEEF, HRESP = 0.
- WAIT_STATES=3, BYTE write 0xA5 @0x03: HREADYOUT low exactly 3 cycles, then mem_we, mem_addr = 0x03.
- WORD read @0xFE: ERR1 then ERR2 (HRESP = 1, HREADYOUT 0→1), no mem_re.
- HALF_WORD write @0x01:
  - ALIGN_CHECK_EN defined → two-cycle ERROR;
  - undefined → mem_we with mem_addr = 0x01.
- Back-to-back NONSEQ writes @0x00, @0x04, then IDLE: two consecutive one-cycle data phases, then HSEL+IDLE gives an OKAY zero-wait response.
- HRESET pulsed during a read's WAIT state: outputs return to reset values immediately, and the next transfer completes normally.
